// File: rtl/slim_pkg.sv
// Shared types and constants for the slime enemy logic.
package slim_pkg;

    typedef enum logic [1:0] {
        WALK_R = 2'd0,
        WALK_L = 2'd1,
        FROZEN = 2'd2
    } slim_state_t;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    // Colour key treated as see-through by the sprite renderers.
    localparam logic [11:0] TRANSPARENT_RGB = 12'h428;

endpackage : slim_pkg

// File: rtl/slim_patrol_tick_gen.sv
// Movement tick generator: one-cycle tick every TICK_DIV enabled clocks.
// The count is cleared while en is low, so the first tick after enabling
// always lands on the TICK_DIV-th enabled cycle.
module tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running 0..TICK_DIV-1 counter, cleared and held while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule : tick_gen

// File: rtl/slim_patrol.sv
// Slime patrol controller: walks between X_MIN and X_MAX at the tick rate,
// stops when hit by the freeze detector.
// Build option: define SLIM_THAW_EN to let a frozen slime thaw after
// FREEZE_TICKS ticks (with thaw_warn during the last FLASH_TICKS ticks);
// without it FROZEN is held until reset.
//
// state  | meaning
// WALK_R | moving right by STEP per tick
// WALK_L | moving left by STEP per tick
// FROZEN | position and direction held
module slim_patrol
    import slim_pkg::*;
#(
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 516,
    parameter int X_INIT       = 48,
    parameter int Y_INIT       = 0,
    parameter int STEP         = 1,
    parameter int TICK_DIV     = 1_000_000,
    parameter int FREEZE_TICKS = 300,
    parameter int FLASH_TICKS  = 50
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           frozen_hit,
    output logic [X_W-1:0] x_slim,
    output logic [Y_W-1:0] y_slim,
    output logic           dir,
    output logic           is_frozen,
    output logic           thaw_warn
);

    // Limit arithmetic is done one bit wider than x so it cannot wrap.
    localparam logic [10:0] X_MIN_W = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W = 11'(X_MAX);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    slim_state_t state;
    logic        tick;
    logic [10:0] x_ext;
    logic [10:0] x_plus;
    logic [10:0] left_lim;

    assign x_ext    = {1'b0, x_slim};
    assign x_plus   = x_ext + STEP_W;
    assign left_lim = X_MIN_W + STEP_W;
    assign y_slim   = Y_W'(Y_INIT);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .tick (tick)
    );

`ifdef SLIM_THAW_EN
    localparam int FC_W = (FREEZE_TICKS > 0) ? $clog2(FREEZE_TICKS + 1) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FREEZE_TICKS);
    localparam int unsigned FLASH_U = FLASH_TICKS;
    // Warning level to show right after a (re)load of the freeze counter.
    localparam bit LOAD_WARN = (FREEZE_TICKS <= FLASH_TICKS) && (FREEZE_TICKS != 0);

    logic [FC_W-1:0] fcnt;
    logic            warn_dec;

    // Warning level the counter will have after this tick's decrement.
    assign warn_dec = (fcnt > FC_W'(1)) && ((32'(fcnt) - 32'd1) <= FLASH_U);
`else
    assign thaw_warn = 1'b0;
`endif

    // Patrol / freeze state machine; all outputs registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= WALK_R;
            x_slim    <= X_W'(X_INIT);
            dir       <= 1'b1;
            is_frozen <= 1'b0;
`ifdef SLIM_THAW_EN
            fcnt      <= '0;
            thaw_warn <= 1'b0;
`endif
        end else if (en) begin
            case (state)
                WALK_R, WALK_L: begin
                    // A hit wins over a same-cycle tick: no move that cycle.
                    if (frozen_hit) begin
                        state     <= FROZEN;
                        is_frozen <= 1'b1;
`ifdef SLIM_THAW_EN
                        fcnt      <= FC_LOAD;
                        thaw_warn <= LOAD_WARN;
`endif
                    end else if (tick) begin
                        if (state == WALK_R) begin
                            if (x_plus >= X_MAX_W) begin
                                x_slim <= X_W'(X_MAX_W);
                                dir    <= 1'b0;
                                state  <= WALK_L;
                            end else begin
                                x_slim <= X_W'(x_plus);
                            end
                        end else begin
                            if (x_ext <= left_lim) begin
                                x_slim <= X_W'(X_MIN_W);
                                dir    <= 1'b1;
                                state  <= WALK_R;
                            end else begin
                                x_slim <= x_slim - X_W'(STEP_W);
                            end
                        end
                    end
                end
                FROZEN: begin
`ifdef SLIM_THAW_EN
                    if (frozen_hit) begin
                        fcnt      <= FC_LOAD;
                        thaw_warn <= LOAD_WARN;
                    end else if (tick) begin
                        if (fcnt <= FC_W'(1)) begin
                            fcnt      <= '0;
                            thaw_warn <= 1'b0;
                            is_frozen <= 1'b0;
                            state     <= dir ? WALK_R : WALK_L;
                        end else begin
                            fcnt      <= fcnt - FC_W'(1);
                            thaw_warn <= warn_dec;
                        end
                    end
`endif
                end
                default: begin
                    state <= WALK_R;
                end
            endcase
        end
    end

endmodule : slim_patrol

// File: doc/slim_patrol.md
# slim_patrol

Per-monster motion controller for the slime enemies. Produces the slime's screen coordinates (`x_slim`, `y_slim`) consumed by the sprite-address, rendering and collision-detection logic in the top level. It consumes the freeze hit from the per-slime freeze detector. One instance is generated per monster. It walks the slime back and forth between two horizontal limits at a divided tick rate, holds it while frozen, and optionally thaws it after a timeout.

## Interface

**Parameters**
- `X_MIN`, 0 — left patrol limit, pixels.
- `X_MAX`, 516 — right patrol limit, pixels; equals 550 minus sprite width (34).
- `X_INIT`, 48 — reset x; requires `X_MIN <= X_INIT <= X_MAX`.
- `Y_INIT`, 0 — constant y row.
- `STEP`, 1 — pixels moved per tick, 1..15.
- `TICK_DIV`, 1_000_000 — `clk` cycles per movement tick (10 ms at 100 MHz).
- `FREEZE_TICKS`, 300 — ticks spent frozen before thaw.
- `FLASH_TICKS`, 50 — number of final frozen ticks during which the warning is shown.

**Ports**
- `clk` in 1 — system clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `en` in 1 — game running; when 0, all state holds.
- `frozen_hit` in 1 — level from the freeze detector.
- `x_slim` out 10 — slime left edge.
- `y_slim` out 9 — slime top edge.
- `dir` out 1 — 0 = left, 1 = right.
- `is_frozen` out 1 — slime frozen.
- `thaw_warn` out 1 — frozen and near thaw.

## Operation

- **Tick generator**
  - Counter runs 0..`TICK_DIV`-1.
  - `tick` is asserted when the count is `TICK_DIV`-1 and `en` = 1; the count then wraps to 0.
  - When `en` = 0, the count clears to 0 and holds.
- **States:** WALK_R, WALK_L, FROZEN.
- **WALK_R on tick:** if `x_slim + STEP >= X_MAX`, set `x_slim = X_MAX`, `dir = 0`, go to WALK_L. Otherwise `x_slim += STEP`.
- **WALK_L on tick:** if `x_slim <= X_MIN + STEP`, set `x_slim = X_MIN`, `dir = 1`, go to WALK_R. Otherwise `x_slim -= STEP`.
- **Width rule:** compute sums and differences at 11 bits. `x_slim` never leaves [`X_MIN`, `X_MAX`] and never wraps.
- **Entering FROZEN:** `frozen_hit` = 1 in either walk state, on any cycle, causes entry to FROZEN.
  - The freeze counter loads `FREEZE_TICKS`.
  - `x_slim` and `dir` hold.
  - `frozen_hit` takes priority over a same-cycle tick; no move occurs on that cycle.
- **FROZEN:**
  - `x_slim` and `dir` hold.
  - `frozen_hit` = 1 reloads the counter to `FREEZE_TICKS` (refreeze).
  - Counting down and thawing follow the rules under Configuration.
- **Outputs**
  - `y_slim` is constantly `Y_INIT`.
  - `is_frozen` = (state == FROZEN).
  - `thaw_warn` = FROZEN and `count <= FLASH_TICKS` and `count != 0`.
- **Reset values:**
  - `x_slim` = `X_INIT`
  - `y_slim` = `Y_INIT`
  - `dir` = 1
  - state WALK_R
  - `is_frozen` = 0
  - `thaw_warn` = 0
  - tick count 0
  - freeze count 0
- **Reset mid-freeze:** returns the block to the reset values immediately (asynchronous reset).

## Timing

- All outputs are registered; there are no combinational input-to-output paths.
- **Movement:** `x_slim` and `dir` update on the edge that ends the tick cycle, so latency is 1 cycle.
- **First tick after reset or `en` rising:** occurs in the `TICK_DIV`-th enabled cycle.
- **Freeze:** `is_frozen` rises on the edge after the first cycle in which `frozen_hit` = 1.
- **Thaw:** `is_frozen` falls on the edge ending the tick that reaches 0.
- **Thaw warning:** `thaw_warn` updates on the same edge as the counter.

## Configuration

Macro: `SLIM_THAW_EN`.

- **Defined:**
  - In FROZEN, each tick decrements the freeze counter.
  - At the tick where the counter is 1, the counter goes to 0 and the block returns to WALK_R if `dir` = 1, otherwise WALK_L.
  - `thaw_warn` is live.
- **Undefined:**
  - FROZEN is absorbing until reset.
  - The freeze counter is not implemented.
  - `thaw_warn` is tied to 0.

## Structure

- **Package `slim_pkg`:**
  - state enum (WALK_R, WALK_L, FROZEN)
  - `X_W` = 10 and `Y_W` = 9 width constants
  - 12-bit transparent colour constant 0x428, shared with renderers
- **Sub-module `tick_gen`:**
  - parameter `TICK_DIV`
  - ports `clk`, `rstn`, `en`, `tick`
  - counter width is `$clog2(TICK_DIV)`

## Test plan

Bench parameters, unless stated otherwise: `TICK_DIV` = 4, `X_MIN` = 0, `X_MAX` = 10, `X_INIT` = 8, `STEP` = 3, `FREEZE_TICKS` = 5, `FLASH_TICKS` = 2, `Y_INIT` = 100.

1. **Reset:** assert `rstn` = 0 asynchronously mid-cycle -> `x_slim` = 8, `y_slim` = 100, `dir` = 1, `is_frozen` = 0, `thaw_warn` = 0 immediately.
2. **Patrol with clamping:** `en` = 1 after reset -> successive ticks give `x_slim` = 10 (`dir` -> 0), then 7, 4, 1, then 0 (`dir` -> 1), then 3; updates arrive every 4 cycles.
3. **Freeze priority:** one-cycle `frozen_hit` coincident with a tick at `x_slim` = 7 -> `x_slim` stays 7 and `is_frozen` = 1 on the next edge.
4. **Thaw (`SLIM_THAW_EN`):** freeze at `x_slim` = 7 with `dir` = 0 ->
   - `thaw_warn` = 1 after 3 ticks;
   - `is_frozen` = 0 after 5 ticks;
   - next tick gives `x_slim` = 4.
5. **Refreeze, then reset:**
   - second `frozen_hit` after 4 frozen ticks -> `thaw_warn` drops to 0 and thaw occurs 5 ticks after the second hit;
   - `rstn` pulse while frozen -> reset values.
6. **`en` gating and no-thaw build:**
   - `en` = 0 for 20 cycles -> all outputs constant, and the first move occurs 4 cycles after `en` returns;
   - build without `SLIM_THAW_EN` -> `is_frozen` stays 1 for 60 ticks and `thaw_warn` stays 0.
